mac_frame_fifo: RTL and testbench
=================================

// Module: mac_frame_fifo
// PURPOSE
//  Store-and-forward frame FIFO for the MAC BFM byte-lane stream (frame/valid/data), parametrised in lane count and depth.
//  Sits between a frame source (driver or MAC RX side) and a consumer that can back-pressure via out_ready.
//  A frame is released only after its EOF beat is stored. Frames that overflow or are aborted are discarded whole and counted.
// PARAMETERS
//  NB      4     byte lanes per beat; data width = 8*NB
//  DEPTH   64    beat entries of storage (power of 2, >=4)
//  CNT_W   16    width of drop_cnt / frame_cnt status counters
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       asynchronous, active-low reset
//  in_frame   in   1       high for the whole duration of an input frame
//  in_valid   in   NB      byte enables; beat present when |in_valid && in_frame
//  in_data    in   8*NB    beat data, lane i = in_data[8i+7:8i]
//  in_eof     in   1       marks the last beat of the frame (qualified by beat present)
//  out_frame  out  1       high while a stored beat is presented
//  out_valid  out  NB      byte enables of the presented beat
//  out_data   out  8*NB    presented beat data
//  out_eof    out  1       presented beat is the last beat of its frame
//  out_ready  in   1       consumer accepts; transfer = out_frame && out_ready
//  frame_cnt  out  CNT_W   number of complete frames held (committed, not fully read)
//  drop_cnt   out  CNT_W   frames discarded, saturating at all-ones
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; pointers, counters and storage-valid cleared; write FSM -> SYNC.
//  Storage: DEPTH x {eof, valid[NB], data}. Pointers wr_ptr, wr_commit, rd_ptr are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//  used = wr_ptr - rd_ptr (modular). Full when used == DEPTH.
//  Write FSM:
//   SYNC  : wait for in_frame==0 -> IDLE. No mid-frame start after reset.
//   IDLE  : beat present -> write it and go to WRITE, or stay in IDLE if that beat also has in_eof (1-beat frame, committed).
//   WRITE : each present beat is written at wr_ptr, wr_ptr++.
//           Present beat with in_eof -> wr_commit <= wr_ptr+1, frame_cnt++, go to IDLE.
//           in_frame falls with no EOF (abort) -> wr_ptr <= wr_commit, drop_cnt++, go to IDLE.
//           Present beat while full -> wr_ptr <= wr_commit, drop_cnt++, go to DROP.
//   DROP  : ignore beats until a present beat with in_eof or in_frame==0 -> IDLE.
//           A full condition on the first beat in IDLE also enters DROP; that beat counts one drop.
//  A beat with in_frame=1 and in_valid=0 is idle; in_eof on it is ignored.
//  Read side: only entries below wr_commit are readable.
//   Output register loads when (!out_frame || out_ready) && rd_ptr != wr_commit; rd_ptr++ on each load.
//   out_* hold stable while out_frame && !out_ready.
//   frame_cnt-- on transfer of an out_eof beat.
//   Same-cycle commit and final-EOF transfer: frame_cnt is unchanged.
//  Latency: EOF beat sampled at edge N -> first beat of that frame visible after edge N+1, if the output is idle.
//   Back-to-back stored frames stream with no bubble while out_ready=1.
//  Simultaneous write and read of the last free slot is allowed. Full is evaluated on used before this edge's read.
//  Frames longer than DEPTH beats are always dropped.
//  Reset mid-frame discards partial input and any unread output. out_frame drops immediately (async).
// STRUCTURE
//  mac_pkg: NB/DEPTH defaults, wr_state_e {SYNC,IDLE,WRITE,DROP}, beat_t struct {eof, valid, data}.
//  Sub-module mac_fifo_ram: simple dual-port RAM, 1 write port, 1 registered read port, no reset on the array.
// TESTING
//  1. Reset release with in_frame=1 mid-frame, 3 beats then fall -> nothing stored, drop_cnt=0 (SYNC).
//  2. 4-beat frame, valid=4'hF, last beat valid=4'h3 with eof -> out_frame 2 cycles after eof; 4 beats, last valid=4'h3, frame_cnt 1->0.
//  3. DEPTH=8, 10-beat frame -> drop_cnt=1, frame_cnt=0; following 2-beat frame is delivered intact.
//  4. in_frame falls after 2 beats, no eof -> wr_ptr rewinds, drop_cnt=1, no output activity.
//  5. Two 3-beat frames queued; out_ready toggles 1,0,1,0 -> out_* stable during stalls; 6 beats delivered in order; eof on beats 3 and 6.
//  6. Fill to DEPTH-1; a concurrent read and a 1-beat frame on the same edge -> accepted, no drop.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC byte-lane frame FIFO.
package mac_pkg;

  localparam int NB_DEF    = 4;
  localparam int DEPTH_DEF = 64;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {SYNC, IDLE, WRITE, DROP} wr_state_e;

  // One stored beat at the default lane count.
  typedef struct packed {
    logic                    eof;
    logic [NB_DEF-1:0]       valid;
    logic [8*NB_DEF-1:0]     data;
  } beat_t;

endpackage

// File: rtl/mac_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module mac_fifo_ram #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mac_frame_fifo.sv
// Store-and-forward frame FIFO: a frame becomes readable only once its EOF beat is stored;
// overflowed or aborted frames are rewound away whole and counted.
module mac_frame_fifo
  import mac_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_frame,
  input  logic [NB-1:0]     in_valid,
  input  logic [8*NB-1:0]   in_data,
  input  logic              in_eof,
  output logic              out_frame,
  output logic [NB-1:0]     out_valid,
  output logic [8*NB-1:0]   out_data,
  output logic              out_eof,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = 1 + NB + 8 * NB;

  typedef struct packed {
    logic              eof;
    logic [NB-1:0]     valid;
    logic [8*NB-1:0]   data;
  } lane_beat_t;

  wr_state_e   state;
  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr, used;
  logic        present, full, wr_en, commit, rd_en, xfer_eof;
  lane_beat_t  wr_beat, rd_beat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign present  = in_frame && (|in_valid);
  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == PW'(DEPTH));
  assign wr_en    = present && !full && (state == IDLE || state == WRITE);
  assign commit   = wr_en && in_eof;
  assign wr_beat  = '{eof: in_eof, valid: in_valid, data: in_data};
  assign rd_en    = (!out_frame || out_ready) && (rd_ptr != wr_commit);
  assign xfer_eof = out_frame && out_ready && rd_beat.eof;

  // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SYNC;
      wr_ptr    <= '0;
      wr_commit <= '0;
      drop_cnt  <= '0;
    end else begin
      if (wr_en)  wr_ptr    <= wr_ptr + 1'b1;
      if (commit) wr_commit <= wr_ptr + 1'b1;
      case (state)
        SYNC:  if (!in_frame) state <= IDLE;
        IDLE: begin
          if (present && full) begin
            drop_cnt <= sat_inc(drop_cnt);
            if (!in_eof) state <= DROP;
          end else if (wr_en && !in_eof) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          // Abort or overflow: rewind to the last committed frame boundary.
          if (!in_frame || (present && full)) begin
            wr_ptr   <= wr_commit;
            drop_cnt <= sat_inc(drop_cnt);
            state    <= (in_frame && !in_eof) ? DROP : IDLE;
          end else if (commit) begin
            state <= IDLE;
          end
        end
        DROP:    if (!in_frame || (present && in_eof)) state <= IDLE;
        default: state <= SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (commit && !xfer_eof) begin
      frame_cnt <= frame_cnt + 1'b1;
    end else if (!commit && xfer_eof) begin
      frame_cnt <= frame_cnt - 1'b1;
    end
  end

  // The RAM read register doubles as the output beat register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      out_frame <= 1'b0;
    end else if (rd_en) begin
      rd_ptr    <= rd_ptr + 1'b1;
      out_frame <= 1'b1;
    end else if (out_ready) begin
      out_frame <= 1'b0;
    end
  end

  mac_fifo_ram #(.WIDTH(BW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_beat),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_beat)
  );

  assign out_valid = out_frame ? rd_beat.valid : '0;
  assign out_data  = out_frame ? rd_beat.data  : '0;
  assign out_eof   = out_frame && rd_beat.eof;

endmodule

// File: tb/tb_mac_frame_fifo.sv
// Randomized bench for mac_frame_fifo against a queue-based frame model.
module tb_mac_frame_fifo;
  import mac_pkg::*;

  localparam int NB    = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_frame = 1'b0;
  logic [NB-1:0]    in_valid = '0;
  logic [8*NB-1:0]  in_data = '0;
  logic             in_eof = 1'b0;
  logic             out_frame;
  logic [NB-1:0]    out_valid;
  logic [8*NB-1:0]  out_data;
  logic             out_eof;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  mac_frame_fifo #(.NB(NB), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_frame  (in_frame),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_eof    (in_eof),
    .out_frame (out_frame),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_eof   (out_eof),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  typedef enum {M_SYNC, M_IDLE, M_BUSY, M_DROP} mmode_e;

  beat_t  cq[$];      // committed beats not yet presented
  beat_t  pq[$];      // beats of the frame being received
  beat_t  m_out;
  bit     m_out_full;
  int     m_frames, m_drops;
  mmode_e m_mode;

  int total = 0;
  int bad = 0;
  int ready_mode = 0;
  int eof_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    pq.delete();
    m_out      = '0;
    m_out_full = 0;
    m_frames   = 0;
    m_drops    = 0;
    m_mode     = M_SYNC;
  endtask

  task automatic model_drop();
    pq.delete();
    if (m_drops < 65535) m_drops++;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    bit present, full, load, xfer_eof;
    beat_t b;
    if (!rst) return;
    present  = in_frame && (in_valid != 0);
    full     = (cq.size() + pq.size()) == DEPTH;
    xfer_eof = m_out_full && out_ready && m_out.eof;
    load     = (!m_out_full || out_ready) && cq.size() > 0;
    if (xfer_eof) m_frames--;
    if (load) begin
      m_out = cq.pop_front();
      m_out_full = 1;
    end else if (out_ready) begin
      m_out_full = 0;
    end
    b = '{eof: in_eof, valid: in_valid, data: in_data};
    case (m_mode)
      M_SYNC: if (!in_frame) m_mode = M_IDLE;
      M_DROP: if (!in_frame || (present && in_eof)) m_mode = M_IDLE;
      default: begin
        if (m_mode == M_BUSY && !in_frame) begin
          model_drop();
          m_mode = M_IDLE;
        end else if (present) begin
          if (full) begin
            model_drop();
            m_mode = in_eof ? M_IDLE : M_DROP;
          end else begin
            pq.push_back(b);
            if (in_eof) begin
              foreach (pq[i]) cq.push_back(pq[i]);
              pq.delete();
              m_frames++;
              m_mode = M_IDLE;
            end else begin
              m_mode = M_BUSY;
            end
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("out_frame", out_frame, m_out_full);
    if (m_out_full)
      check("out_beat", {out_eof, out_valid, out_data}, {m_out.eof, m_out.valid, m_out.data});
    check("frame_cnt", frame_cnt, m_frames);
    check("drop_cnt", drop_cnt, m_drops);
  endtask

  task automatic step();
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
    if (out_frame && out_ready && out_eof) eof_seen++;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic f, input logic [NB-1:0] v, input logic e);
    in_frame = f;
    in_valid = v;
    in_eof   = e;
    in_data  = $urandom;
  endtask

  task automatic send_frame(input int nbeats, input logic [NB-1:0] last_v,
                            input bit with_eof, input int idle_pct);
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 99) < idle_pct) begin
        drive(1'b1, '0, 1'($urandom_range(0, 1)));
        step();
      end
      if (i == nbeats - 1) drive(1'b1, last_v, with_eof);
      else drive(1'b1, 4'($urandom_range(1, 15)), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    step();
  endtask

  initial begin
    model_reset();

    // Reset asserted mid-frame, released while the frame continues.
    drive(1'b1, 4'hF, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    repeat (3) begin
      drive(1'b1, 4'hF, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    repeat (2) step();
    check("t1_frames", frame_cnt, 0);
    check("t1_drop", drop_cnt, 0);
    check("t1_idle", out_frame, 0);

    // 4-beat frame, short last beat; latency of first output beat.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hF, 1'b0);
      step();
    end
    drive(1'b1, 4'h3, 1'b1);
    step();
    check("t2_commit", frame_cnt, 1);
    check("t2_not_yet", out_frame, 0);
    drive(1'b0, '0, 1'b0);
    step();
    check("t2_first_beat", out_frame, 1);
    repeat (5) step();
    check("t2_frames_done", frame_cnt, 0);

    // Oversize frame dropped, next frame intact.
    send_frame(10, 4'hF, 1, 0);
    check("t3_drop", drop_cnt, 1);
    check("t3_frames", frame_cnt, 0);
    send_frame(2, 4'h1, 1, 0);
    repeat (4) step();

    // Abort after 2 beats.
    send_frame(2, 4'hF, 0, 0);
    check("t4_drop", drop_cnt, 2);
    check("t4_no_out", out_frame, 0);

    // Two queued frames drained with ready toggling.
    ready_mode = 3;
    eof_seen = 0;
    send_frame(3, 4'h7, 1, 0);
    send_frame(3, 4'hC, 1, 0);
    ready_mode = 2;
    repeat (16) step();
    check("t5_eofs", eof_seen, 2);
    check("t5_frames", frame_cnt, 0);

    // Fill to DEPTH-1, then concurrent read and 1-beat write.
    ready_mode = 3;
    send_frame(DEPTH, 4'hF, 1, 0);
    check("t6_frames", frame_cnt, 1);
    ready_mode = 0;
    drive(1'b1, 4'h5, 1'b1);
    step();
    check("t6_no_drop", drop_cnt, 2);
    check("t6_frames2", frame_cnt, 2);
    drive(1'b0, '0, 1'b0);
    repeat (2 * DEPTH + 4) step();

    // Randomized traffic.
    for (int f = 0; f < 150; f++) begin
      ready_mode = $urandom_range(0, 3);
      send_frame($urandom_range(1, 11), 4'($urandom_range(1, 15)),
                 ($urandom_range(0, 9) != 0), 20);
      repeat ($urandom_range(0, 2)) step();
    end

    // Reset with a held output beat and a partial input frame.
    ready_mode = 0;
    repeat (2 * DEPTH + 4) step();
    ready_mode = 3;
    send_frame(3, 4'hF, 1, 0);
    drive(1'b1, 4'hF, 1'b0);
    repeat (2) step();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_out_frame", out_frame, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) begin
      drive(1'b1, 4'hF, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    step();
    ready_mode = 0;
    send_frame(3, 4'h3, 1, 0);

    drive(1'b0, '0, 1'b0);
    repeat (2 * DEPTH + 4) step();
    check("drain_empty", out_frame, 0);
    check("drain_frames", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
